// File: rtl/vm_input_channel.sv
// vm_input_channel
// NChannels independent circular-buffer FIFOs feeding the program engine.
// A host appends words through a valid/ready handshake; the engine pops words
// with the in instruction (rd_en) and queries the fill level with inSize (size).
// Build option: define VM_INPUT_CHANNEL_PRELOAD_EN to have reset load channel 0
// with the NPreload words of PreloadData (word 0 popped first); with the macro
// undefined every channel comes out of reset empty.
module vm_input_channel #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn                = 16,
  parameter int NChannels          = 2,
  parameter int NPreload           = 2,
  parameter logic [NPreload*MemoryElementWidth-1:0] PreloadData = {12'd44, 12'd88},
  localparam int CS = (NChannels > 1) ? $clog2(NChannels) : 1,
  localparam int CW = $clog2(NIn + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_valid,
  input  logic [CS-1:0]                 load_channel,
  input  logic [MemoryElementWidth-1:0] load_data,
  output logic                          load_ready,
  input  logic                          rd_en,
  input  logic [CS-1:0]                 rd_channel,
  output logic [MemoryElementWidth-1:0] rd_data,
  output logic                          rd_valid,
  input  logic [CS-1:0]                 size_channel,
  output logic [CW-1:0]                 size,
  output logic                          underflow,
  output logic                          overflow
);

  localparam int PW = $clog2(NIn);

  // Reset image of channel 0; every other channel always resets empty.
`ifdef VM_INPUT_CHANNEL_PRELOAD_EN
  localparam logic [CW-1:0] Ch0CountRst = CW'(NPreload);
  localparam logic [PW-1:0] Ch0WptrRst  = PW'(NPreload % NIn);
`else
  localparam logic [CW-1:0] Ch0CountRst = '0;
  localparam logic [PW-1:0] Ch0WptrRst  = '0;
  // Preload parameters are meaningless in this build; fold them into a sink.
  logic unused_preload;
  assign unused_preload = ^{PreloadData, 32'(NPreload)};
`endif

  // Per-channel bookkeeping.
  logic [MemoryElementWidth-1:0] mem_q   [NChannels][NIn];
  logic [CW-1:0]                 count_q [NChannels];
  logic [CW-1:0]                 count_d [NChannels];
  logic [PW-1:0]                 rptr_q  [NChannels];
  logic [PW-1:0]                 rptr_d  [NChannels];
  logic [PW-1:0]                 wptr_q  [NChannels];
  logic [PW-1:0]                 wptr_d  [NChannels];
  logic                          push_hit [NChannels];
  logic                          pop_hit  [NChannels];

  // Output-side registers.
  logic [MemoryElementWidth-1:0] rd_data_q, rd_data_d;
  logic                          rd_valid_q, rd_valid_d;
  logic                          underflow_q, underflow_d;
  logic                          overflow_q, overflow_d;

  // Channel-select decoding and the accepted push/pop for this cycle.
  logic load_sel_ok;
  logic rd_sel_ok;
  logic size_sel_ok;
  logic push;
  logic pop_ok;

  // Circular pointer advance with explicit wrap, so NIn need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NIn - 1)) ? '0 : p + PW'(1);
  endfunction

  // Selects at or above NChannels address nothing and behave as no-ops.
  assign load_sel_ok = (32'(load_channel) < NChannels);
  assign rd_sel_ok   = (32'(rd_channel) < NChannels);
  assign size_sel_ok = (32'(size_channel) < NChannels);

  // No full-bypass: a full channel refuses a word even if it is popped this cycle.
  // Held low during reset so the host sees readiness only once reset releases.
  assign load_ready = !reset && load_sel_ok && (count_q[load_channel] != CW'(NIn));
  assign push       = load_valid && load_ready;

  // An empty channel never yields a word, even if it is being pushed this cycle.
  assign pop_ok = rd_en && rd_sel_ok && (count_q[rd_channel] != '0);

  // inSize sees the pre-edge count.
  assign size = size_sel_ok ? count_q[size_channel] : '0;

  // Per-channel pointer and count update from the decoded push/pop.
  always_comb begin
    for (int c = 0; c < NChannels; c++) begin
      // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
      push_hit[c] = push && (32'(load_channel) == c);
      pop_hit[c]  = pop_ok && (32'(rd_channel) == c);
      count_d[c]  = count_q[c];
      rptr_d[c]   = rptr_q[c];
      wptr_d[c]   = wptr_q[c];
      if (push_hit[c]) begin
        wptr_d[c] = ptr_inc(wptr_q[c]);
      end
      if (pop_hit[c]) begin
        rptr_d[c] = ptr_inc(rptr_q[c]);
      end
      case ({push_hit[c], pop_hit[c]})
        2'b10:   count_d[c] = count_q[c] + CW'(1);
        2'b01:   count_d[c] = count_q[c] - CW'(1);
        default: count_d[c] = count_q[c];
      endcase
    end
  end

  // Read-port register and sticky error flags.
  always_comb begin
    rd_data_d   = rd_data_q;
    rd_valid_d  = pop_ok;
    underflow_d = underflow_q | (rd_en & ~pop_ok);
    overflow_d  = overflow_q | (load_valid & ~load_ready);
    if (pop_ok) begin
      rd_data_d = mem_q[rd_channel][rptr_q[rd_channel]];
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NChannels; c++) begin
        count_q[c] <= (c == 0) ? Ch0CountRst : '0;
        wptr_q[c]  <= (c == 0) ? Ch0WptrRst : '0;
        rptr_q[c]  <= '0;
      end
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      for (int c = 0; c < NChannels; c++) begin
        count_q[c] <= count_d[c];
        wptr_q[c]  <= wptr_d[c];
        rptr_q[c]  <= rptr_d[c];
      end
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: FIFO storage is not reset; count and pointers decide which words are live,
  // so clearing the array would only add reset fan-out (only preload words need a value).
`ifdef VM_INPUT_CHANNEL_PRELOAD_EN
  // Storage write; reset seeds channel 0 with the preload words.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPreload; i++) begin
        mem_q[0][i] <= PreloadData[i*MemoryElementWidth +: MemoryElementWidth];
      end
    end else if (push) begin
      mem_q[load_channel][wptr_q[load_channel]] <= load_data;
    end
  end
`else
  // Storage write on an accepted push.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[load_channel][wptr_q[load_channel]] <= load_data;
    end
  end
`endif

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign underflow = underflow_q;
  assign overflow  = overflow_q;

endmodule
